// File: rtl/mem_pipe_reg_pkg.sv
// Shared types and default widths for the memory pipeline stage register.
package mem_pipe_reg_pkg;

  localparam int PAYLOAD_WD_DEF = 160;
  localparam int RDATA_WD_DEF   = 32;
  localparam int STALL_WD_DEF   = 6;
  localparam int STAGE_IDX_DEF  = 4;

  typedef enum logic {
    PASS = 1'b0,
    HOLD = 1'b1
  } hold_state_e;

endpackage

// File: rtl/mem_pipe_reg_rdata_hold.sv
// Keeps SRAM read data stable while the downstream stage is stalled.
module rdata_hold
  import mem_pipe_reg_pkg::*;
#(
  parameter int RDATA_WD = RDATA_WD_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                hold_req,
  input  logic                valid,
  input  logic                flush,
  input  logic [RDATA_WD-1:0] sram_rdata,
  output logic [RDATA_WD-1:0] rdata
);

  hold_state_e       state_q;
  hold_state_e       state_d;
  logic              capture;
  logic [RDATA_WD-1:0] hold_q;

  // A flushed instruction is dead, so there is nothing worth holding for it.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      PASS: begin
        if (hold_req && valid && !flush) begin
          state_d = HOLD;
          capture = 1'b1;
        end
      end
      HOLD: begin
        if (!hold_req || flush) begin
          state_d = PASS;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= PASS;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        hold_q <= sram_rdata;
      end
    end
  end

  assign rdata = (state_q == HOLD) ? hold_q : sram_rdata;

endmodule

// File: rtl/mem_pipe_reg.sv
// Execute-to-memory stage register with read-data hold.
// Optional perf counters: define MEM_PIPE_PERF_EN.
module mem_pipe_reg
  import mem_pipe_reg_pkg::*;
#(
  parameter int PAYLOAD_WD = PAYLOAD_WD_DEF,
  parameter int RDATA_WD   = RDATA_WD_DEF,
  parameter int STALL_WD   = STALL_WD_DEF,
  parameter int STAGE_IDX  = STAGE_IDX_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [STALL_WD-1:0]            stall,
  input  logic                           flush,
  input  logic [PAYLOAD_WD-1:0]          in_payload,
  input  logic                           in_valid,
  input  logic [RDATA_WD-1:0]            sram_rdata,
  output logic [PAYLOAD_WD+RDATA_WD-1:0] out_bus,
  output logic                           out_valid
`ifdef MEM_PIPE_PERF_EN
  ,
  output logic [31:0]                    perf_stall_cnt,
  output logic [31:0]                    perf_bubble_cnt
`endif
);

  logic                  stall_cur;
  logic                  stall_nxt;
  logic                  unused_stall;
  logic [PAYLOAD_WD-1:0] payload_q;
  logic                  valid_q;
  logic [RDATA_WD-1:0]   rdata_eff;

  assign stall_cur    = stall[STAGE_IDX];
  assign stall_nxt    = stall[STAGE_IDX+1];
  assign unused_stall = ^stall;

  // Downstream stall freezes us even if our own bit is clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      payload_q <= '0;
      valid_q   <= 1'b0;
    end else if (flush) begin
      payload_q <= '0;
      valid_q   <= 1'b0;
    end else if (stall_nxt) begin
      payload_q <= payload_q;
      valid_q   <= valid_q;
    end else if (stall_cur) begin
      payload_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      payload_q <= in_payload;
      valid_q   <= in_valid;
    end
  end

  rdata_hold #(
    .RDATA_WD(RDATA_WD)
  ) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .hold_req  (stall_nxt),
    .valid     (valid_q),
    .flush     (flush),
    .sram_rdata(sram_rdata),
    .rdata     (rdata_eff)
  );

  assign out_bus   = {payload_q, rdata_eff};
  assign out_valid = valid_q;

`ifdef MEM_PIPE_PERF_EN
  logic bubble;

  assign bubble = stall_cur && !stall_nxt && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (stall_cur && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (bubble && (perf_bubble_cnt != 32'hFFFF_FFFF)) begin
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_pipe_reg.sv
// Directed vector bench for mem_pipe_reg (default widths).
module tb_mem_pipe_reg;

  localparam int PW = 160;
  localparam int RW = 32;
  localparam int SW = 6;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [SW-1:0]  stall;
  logic           flush;
  logic [PW-1:0]  in_payload;
  logic           in_valid;
  logic [RW-1:0]  sram_rdata;
  logic [PW+RW-1:0] out_bus;
  logic           out_valid;
`ifdef MEM_PIPE_PERF_EN
  logic [31:0]    perf_stall_cnt;
  logic [31:0]    perf_bubble_cnt;
`endif

  mem_pipe_reg dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .flush     (flush),
    .in_payload(in_payload),
    .in_valid  (in_valid),
    .sram_rdata(sram_rdata),
    .out_bus   (out_bus),
    .out_valid (out_valid)
`ifdef MEM_PIPE_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [5:0]  stall;
    logic        flush;
    logic        in_valid;
    logic [31:0] pay;
    logic [31:0] rd;
    logic        exp_v;
    logic [31:0] exp_p;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt[25];
  int   nchk  = 0;
  int   npass = 0;

  task automatic chk(input string nm, input int idx,
                     input logic [PW-1:0] act, input logic [PW-1:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
  endtask

  task automatic drive(input logic r, input logic [5:0] s,
                       input logic f, input logic v,
                       input logic [PW-1:0] p, input logic [31:0] rd);
    @(negedge clk);
    rst_n      = r;
    stall      = s;
    flush      = f;
    in_valid   = v;
    in_payload = p;
    sram_rdata = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [PW-1:0] wide;
    rst_n      = 1'b0;
    stall      = '0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_payload = '0;
    sram_rdata = '0;

    //         rst  stall      fl v  pay    rdata          ev ep     erd
    vt[0]  = '{0, 6'b000000, 0, 1, 32'hA5, 32'h1,        0, 32'h0,  32'h1};
    vt[1]  = '{0, 6'b000000, 0, 1, 32'hA5, 32'h2,        0, 32'h0,  32'h2};
    vt[2]  = '{0, 6'b000000, 0, 1, 32'hA5, 32'h3,        0, 32'h0,  32'h3};
    vt[3]  = '{1, 6'b000000, 0, 1, 32'hA5, 32'h4,        1, 32'hA5, 32'h4};
    vt[4]  = '{1, 6'b010000, 0, 1, 32'hB6, 32'h5,        0, 32'h0,  32'h5};
    vt[5]  = '{1, 6'b000000, 0, 1, 32'hC7, 32'h6,        1, 32'hC7, 32'h6};
    vt[6]  = '{1, 6'b110000, 0, 1, 32'hD8, 32'h11223344, 1, 32'hC7, 32'h11223344};
    vt[7]  = '{1, 6'b110000, 0, 1, 32'hD8, 32'hDEADBEEF, 1, 32'hC7, 32'h11223344};
    vt[8]  = '{1, 6'b110000, 0, 1, 32'hD8, 32'hDEADBEEF, 1, 32'hC7, 32'h11223344};
    vt[9]  = '{1, 6'b000000, 0, 1, 32'hE9, 32'h55,       1, 32'hE9, 32'h55};
    vt[10] = '{1, 6'b110000, 0, 1, 32'hF0, 32'h66,       1, 32'hE9, 32'h66};
    vt[11] = '{1, 6'b110000, 1, 1, 32'hF0, 32'h77,       0, 32'h0,  32'h77};
    vt[12] = '{1, 6'b110000, 0, 1, 32'hF1, 32'h88,       0, 32'h0,  32'h88};
    vt[13] = '{1, 6'b110000, 0, 1, 32'hF1, 32'h99,       0, 32'h0,  32'h99};
    vt[14] = '{1, 6'b000000, 0, 1, 32'h12, 32'hAA,       1, 32'h12, 32'hAA};
    vt[15] = '{1, 6'b100000, 0, 1, 32'h34, 32'hBB,       1, 32'h12, 32'hBB};
    vt[16] = '{1, 6'b100000, 0, 1, 32'h34, 32'hCC,       1, 32'h12, 32'hBB};
    vt[17] = '{1, 6'b000000, 0, 0, 32'h56, 32'hDD,       0, 32'h56, 32'hDD};
    vt[18] = '{1, 6'b000000, 0, 1, 32'h78, 32'hEE,       1, 32'h78, 32'hEE};
    vt[19] = '{1, 6'b110000, 0, 1, 32'h79, 32'hF0,       1, 32'h78, 32'hF0};
    vt[20] = '{0, 6'b110000, 0, 1, 32'h79, 32'hF1,       0, 32'h0,  32'hF1};
    vt[21] = '{1, 6'b110000, 0, 1, 32'h79, 32'hF2,       0, 32'h0,  32'hF2};
    vt[22] = '{1, 6'b000000, 0, 1, 32'h9A, 32'hF3,       1, 32'h9A, 32'hF3};
    vt[23] = '{1, 6'b010000, 1, 1, 32'h9B, 32'hF4,       0, 32'h0,  32'hF4};
    vt[24] = '{1, 6'b000000, 0, 1, 32'h9C, 32'hF5,       1, 32'h9C, 32'hF5};

    for (int i = 0; i < 25; i++) begin
      drive(vt[i].rst_n, vt[i].stall, vt[i].flush, vt[i].in_valid,
            {128'b0, vt[i].pay}, vt[i].rd);
      chk("valid", i, {159'b0, out_valid}, {159'b0, vt[i].exp_v});
      chk("payload", i, out_bus[PW+RW-1:RW], {128'b0, vt[i].exp_p});
      chk("rdata", i, {128'b0, out_bus[RW-1:0]}, {128'b0, vt[i].exp_rd});
    end

    // Full-width payload reaches the MSBs untouched.
    wide = {32'hCAFEF00D, 32'h0BADC0DE, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F};
    drive(1, 6'b000000, 0, 1, wide, 32'h13579BDF);
    chk("wide_pay", 0, out_bus[PW+RW-1:RW], wide);
    chk("wide_rd", 0, {128'b0, out_bus[RW-1:0]}, {128'b0, 32'h13579BDF});

    // Plain flush with no stall kills the incoming load as well.
    drive(1, 6'b000000, 1, 1, wide, 32'h2468ACE0);
    chk("flush_v", 0, {159'b0, out_valid}, 160'b0);
    chk("flush_p", 0, out_bus[PW+RW-1:RW], 160'b0);

`ifdef MEM_PIPE_PERF_EN
    drive(0, 6'b000000, 0, 0, '0, 32'h0);
    chk("perf_rst_s", 0, {128'b0, perf_stall_cnt}, 160'b0);
    chk("perf_rst_b", 0, {128'b0, perf_bubble_cnt}, 160'b0);
    drive(1, 6'b000000, 0, 1, {128'b0, 32'h42}, 32'h0);
    drive(1, 6'b010000, 0, 1, {128'b0, 32'h43}, 32'h0);
    chk("perf_bub", 0, {128'b0, perf_bubble_cnt}, {128'b0, 32'd1});
    chk("perf_stl", 0, {128'b0, perf_stall_cnt}, {128'b0, 32'd1});
    @(negedge clk);
    force dut.perf_stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.perf_stall_cnt;
    drive(1, 6'b110000, 0, 1, '0, 32'h0);
    drive(1, 6'b110000, 0, 1, '0, 32'h0);
    drive(1, 6'b110000, 0, 1, '0, 32'h0);
    chk("perf_sat", 0, {128'b0, perf_stall_cnt}, {128'b0, 32'hFFFF_FFFF});
`endif

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/mem_pipe_reg.md
MEM_PIPE_REG -- requirements
Module: mem_pipe_reg

Interface
REQ-001 Parameter PAYLOAD_WD, default 160: width of the incoming execute-to-memory bus.
REQ-002 Parameter RDATA_WD, default 32: data SRAM read-data width.
REQ-003 Parameter STALL_WD, default 6: stall vector width.
REQ-004 Parameter STAGE_IDX, default 4: stall bit owned by this stage; STAGE_IDX+1 < STALL_WD.
REQ-005 clk  in  1  clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 stall  in  STALL_WD  pipeline stall vector, bit i freezes stage i.
REQ-008 flush  in  1  kill the instruction held in this stage.
REQ-009 in_payload  in  PAYLOAD_WD  upstream bus.
REQ-010 in_valid  in  1  upstream bus carries a live instruction.
REQ-011 sram_rdata  in  RDATA_WD  data SRAM read data, valid one cycle after the request.
REQ-012 out_bus  out  PAYLOAD_WD+RDATA_WD  {held payload, effective read data}, payload in the MSBs.
REQ-013 out_valid  out  1  held instruction is live.

Function
REQ-014 Stage register SHALL load in_payload/in_valid at the edge when stall[STAGE_IDX]=0: latency exactly one cycle.
REQ-015 When stall[STAGE_IDX]=1 and stall[STAGE_IDX+1]=0, the stage SHALL insert a bubble: payload <= 0, valid <= 0.
REQ-016 When stall[STAGE_IDX]=1 and stall[STAGE_IDX+1]=1, payload and valid SHALL hold.
REQ-017 flush=1 SHALL clear payload and valid at the next edge, with priority over every stall combination.
REQ-018 Read-data hold FSM SHALL have states PASS and HOLD; effective read data = sram_rdata in PASS, hold_data in HOLD.
REQ-019 PASS->HOLD at the edge where stall[STAGE_IDX+1]=1 and valid=1, capturing sram_rdata into hold_data that cycle.
REQ-020 HOLD->PASS at the edge where stall[STAGE_IDX+1]=0 or flush=1; hold_data SHALL NOT change while in HOLD.
REQ-021 In PASS with valid=0 and stall[STAGE_IDX+1]=1, FSM SHALL stay in PASS (no capture for bubbles).
REQ-022 stall[STAGE_IDX+1]=1 with stall[STAGE_IDX]=0 is illegal and SHALL be treated as a full hold (REQ-016).
REQ-023 Outputs SHALL be driven purely from registers plus the single read-data mux; no other combinational path from inputs.

Reset
REQ-024 rst_n=0 at an edge SHALL clear payload, valid, hold_data to 0 and FSM to PASS; reset overrides flush and stall.
REQ-025 While in reset, out_bus SHALL equal {PAYLOAD_WD'0, sram_rdata} and out_valid SHALL be 0 from the first post-reset cycle.
REQ-026 Reset asserted mid-HOLD SHALL discard hold_data; no captured value survives reset.

Configuration
REQ-027 Macro MEM_PIPE_PERF_EN defined: add outputs perf_stall_cnt[31:0] (cycles with stall[STAGE_IDX]=1) and perf_bubble_cnt[31:0] (bubbles per REQ-015), both saturating at 0xFFFFFFFF, cleared by reset.
REQ-028 MEM_PIPE_PERF_EN undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-029 Shared package SHALL hold STALL_WD default, the FSM state encoding (PASS=0, HOLD=1), and the default bus widths.
REQ-030 Read-data hold FSM plus hold_data register SHALL be sub-module rdata_hold, parametrised by RDATA_WD.

Verification
REQ-031 Reset 3 cycles, in_valid=1, payload=0xA5 -> out_valid=0 during reset; one cycle after release payload=0xA5, out_valid=1.
REQ-032 stall=6'b010000 one cycle with valid instruction -> next cycle payload=0, out_valid=0, perf_bubble_cnt=1 when enabled.
REQ-033 stall=6'b110000 for 3 cycles, sram_rdata=0x11223344 then 0xDEADBEEF -> out_bus read data stays 0x11223344 all 3 cycles; PASS after release.
REQ-034 flush=1 together with stall=6'b110000 in HOLD -> next cycle out_valid=0, FSM PASS, read data follows sram_rdata.
REQ-035 Bubble held with stall=6'b110000 -> FSM remains PASS, read data tracks sram_rdata.
REQ-036 MEM_PIPE_PERF_EN defined, perf_stall_cnt forced to 0xFFFFFFFE, 3 stall cycles -> counter reads 0xFFFFFFFF.
